// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter in front of one single-ported memory.
// Registers the winning request, drives the memory port, waits LATENCY cycles on reads, then acks.
module mem_port_arbiter #(
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    input  logic        we0,
    input  logic        we1,
    output logic [31:0] rdata0,
    output logic [31:0] rdata1,
    output logic        ack0,
    output logic        ack1,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_out,
    output logic        mem_we,
    input  logic [31:0] mem_data_in,
    output logic        busy,
    output logic        grant_id
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t      state, state_d;
    logic [3:0]  cnt, cnt_d;
    logic        last_grant, last_grant_d;
    logic        we_q, we_q_d;
    logic        gnt;
    logic [31:0] rdata0_d, rdata1_d, mem_address_d, mem_data_out_d;
    logic        ack0_d, ack1_d, mem_we_d, busy_d, grant_id_d;

    always_comb begin
        state_d        = state;
        cnt_d          = cnt;
        last_grant_d   = last_grant;
        we_q_d         = we_q;
        rdata0_d       = rdata0;
        rdata1_d       = rdata1;
        mem_address_d  = mem_address;
        mem_data_out_d = mem_data_out;
        grant_id_d     = grant_id;
        ack0_d         = 1'b0;
        ack1_d         = 1'b0;
        mem_we_d       = 1'b0;
        // Contended requests go to whoever was not served last.
        gnt            = (req0 && req1) ? ~last_grant : req1;

        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    mem_address_d  = gnt ? addr1 : addr0;
                    mem_data_out_d = gnt ? wdata1 : wdata0;
                    we_q_d         = gnt ? we1 : we0;
                    mem_we_d       = gnt ? we1 : we0;
                    grant_id_d     = gnt;
                    last_grant_d   = gnt;
                    state_d        = ISSUE;
                end
            end
            ISSUE: begin
                if (we_q) begin
                    ack0_d  = ~grant_id;
                    ack1_d  = grant_id;
                    state_d = DONE;
                end else begin
                    cnt_d   = 4'(LATENCY);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    if (grant_id) rdata1_d = mem_data_in;
                    else          rdata0_d = mem_data_in;
                    ack0_d  = ~grant_id;
                    ack1_d  = grant_id;
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            last_grant   <= 1'b1;
            we_q         <= 1'b0;
            rdata0       <= '0;
            rdata1       <= '0;
            mem_address  <= '0;
            mem_data_out <= '0;
            grant_id     <= 1'b0;
            ack0         <= 1'b0;
            ack1         <= 1'b0;
            mem_we       <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_d;
            cnt          <= cnt_d;
            last_grant   <= last_grant_d;
            we_q         <= we_q_d;
            rdata0       <= rdata0_d;
            rdata1       <= rdata1_d;
            mem_address  <= mem_address_d;
            mem_data_out <= mem_data_out_d;
            grant_id     <= grant_id_d;
            ack0         <= ack0_d;
            ack1         <= ack1_d;
            mem_we       <= mem_we_d;
            busy         <= busy_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: LATENCY=1 instance for most cases, LATENCY=3 instance for the long read.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1, req0_3, req1_3;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        we0, we1;

    logic [31:0] rdata0, rdata1, mem_address, mem_data_out, mem_data_in;
    logic        ack0, ack1, mem_we, busy, grant_id;
    logic [31:0] rdata0_3, rdata1_3, mem_address_3, mem_data_out_3, mem_data_in_3;
    logic        ack0_3, ack1_3, mem_we_3, busy_3, grant_id_3;

    logic [31:0] mem [0:255];
    logic [255:0] written = '0;
    int          we_cnt = 0;
    int          n_chk = 0, n_pass = 0;

    always #5 clk = ~clk;

    // Memory model: unwritten words return a pattern derived from the address, 0x40 holds 0x12345678.
    assign mem_data_in = written[mem_address[9:2]] ? mem[mem_address[9:2]] :
                         (mem_address == 32'h40) ? 32'h12345678 : (32'hC0DE0000 | mem_address);
    assign mem_data_in_3 = (mem_address_3 == 32'h40) ? 32'h12345678 : (32'hC0DE0000 | mem_address_3);

    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_address[9:2]]     <= mem_data_out;
            written[mem_address[9:2]] <= 1'b1;
            we_cnt                    <= we_cnt + 1;
        end
    end

    mem_port_arbiter #(.LATENCY(1)) dut (
        .clk(clk), .reset(reset), .req0(req0), .req1(req1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .we0(we0), .we1(we1), .rdata0(rdata0), .rdata1(rdata1),
        .ack0(ack0), .ack1(ack1), .mem_address(mem_address),
        .mem_data_out(mem_data_out), .mem_we(mem_we), .mem_data_in(mem_data_in),
        .busy(busy), .grant_id(grant_id)
    );

    mem_port_arbiter #(.LATENCY(3)) dut3 (
        .clk(clk), .reset(reset), .req0(req0_3), .req1(req1_3),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .we0(we0), .we1(we1), .rdata0(rdata0_3), .rdata1(rdata1_3),
        .ack0(ack0_3), .ack1(ack1_3), .mem_address(mem_address_3),
        .mem_data_out(mem_data_out_3), .mem_we(mem_we_3), .mem_data_in(mem_data_in_3),
        .busy(busy_3), .grant_id(grant_id_3)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int we_before;
        reset = 1'b1; req0 = 0; req1 = 0; req0_3 = 0; req1_3 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0; we0 = 0; we1 = 0;
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_ack", {ack0, ack1}, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_mem_address", mem_address, 0);
        chk("rst_mem_data_out", mem_data_out, 0);
        chk("rst_rdata", {rdata0 | rdata1}, 0);

        // Single write by requester 0
        reset = 0; req0 = 1; we0 = 1; addr0 = 32'h100; wdata0 = 32'hDEADBEEF;
        tick();
        chk("wr_mem_we", mem_we, 1);
        chk("wr_mem_address", mem_address, 32'h100);
        chk("wr_mem_data_out", mem_data_out, 32'hDEADBEEF);
        chk("wr_busy", busy, 1);
        chk("wr_ack0_early", ack0, 0);
        tick();
        chk("wr_ack0", ack0, 1);
        chk("wr_ack1", ack1, 0);
        chk("wr_mem_we_off", mem_we, 0);
        req0 = 0; we0 = 0;
        tick();
        chk("wr_ack0_pulse", ack0, 0);
        chk("wr_idle", busy, 0);

        // Read by requester 1, LATENCY=1
        we_before = we_cnt;
        req1 = 1; we1 = 0; addr1 = 32'h40; wdata1 = 32'h55550000;
        tick();
        chk("rd1_grant", grant_id, 1);
        tick();
        chk("rd1_ack_early", ack1, 0);
        tick();
        chk("rd1_ack1", ack1, 1);
        chk("rd1_rdata1", rdata1, 32'h12345678);
        chk("rd1_rdata0", rdata0, 0);
        req1 = 0;
        tick();
        chk("rd1_ack_pulse", ack1, 0);
        chk("rd1_no_we", we_cnt, we_before);

        // Read by requester 1, LATENCY=3
        req1_3 = 1;
        tick();
        chk("rd3_grant", grant_id_3, 1);
        chk("rd3_busy", busy_3, 1);
        chk("rd3_mem_we", mem_we_3, 0);
        chk("rd3_addr", mem_address_3, 32'h40);
        chk("rd3_wdata_latched", mem_data_out_3, 32'h55550000);
        tick(); tick(); tick();
        chk("rd3_ack_early", ack1_3, 0);
        tick();
        chk("rd3_ack1", ack1_3, 1);
        chk("rd3_ack0", ack0_3, 0);
        chk("rd3_rdata1", rdata1_3, 32'h12345678);
        chk("rd3_rdata0", rdata0_3, 0);
        req1_3 = 0;
        tick();
        chk("rd3_ack_pulse", ack1_3, 0);

        // Contention after reset: grants alternate starting with requester 0
        reset = 1; tick(); reset = 0;
        req0 = 1; req1 = 1; we0 = 0; we1 = 0; addr0 = 32'h60; addr1 = 32'h40;
        for (int g = 0; g < 4; g++) begin
            tick();
            chk($sformatf("cont_grant%0d", g), grant_id, g % 2);
            tick(); tick();
            chk($sformatf("cont_ack%0d", g), {ack1, ack0}, (g % 2) ? 2'b10 : 2'b01);
            tick();
        end
        chk("cont_rdata0", rdata0, 32'hC0DE0060);
        chk("cont_rdata1", rdata1, 32'h12345678);
        req0 = 0; req1 = 0;
        tick();

        // Inputs change and req drops mid-transaction
        req0 = 1; addr0 = 32'h10;
        tick();
        tick();
        addr0 = 32'h20; req0 = 0;
        tick();
        chk("chg_ack0", ack0, 1);
        chk("chg_addr", mem_address, 32'h10);
        chk("chg_rdata0", rdata0, 32'hC0DE0010);
        tick();

        // Reset during WAIT of a requester-0 read
        req0 = 1; addr0 = 32'h10;
        tick();
        tick();
        reset = 1; req0 = 0;
        tick();
        chk("rstw_ack0", ack0, 0);
        chk("rstw_busy", busy, 0);
        chk("rstw_rdata", {rdata0 | rdata1}, 0);
        chk("rstw_addr", mem_address, 0);
        reset = 0;
        tick();
        chk("rstw_no_ack", {ack0, ack1}, 0);

        // Contended write by 0 then read by 1 of the same word
        req0 = 1; we0 = 1; addr0 = 32'h80; wdata0 = 32'hA5A5A5A5;
        req1 = 1; we1 = 0; addr1 = 32'h80;
        tick();
        chk("wr_rd_grant0", grant_id, 0);
        chk("wr_rd_mem_we", mem_we, 1);
        tick();
        chk("wr_rd_ack0", ack0, 1);
        req0 = 0;
        tick();
        tick();
        chk("wr_rd_grant1", grant_id, 1);
        tick();
        tick();
        chk("wr_rd_ack1", ack1, 1);
        chk("wr_rd_rdata1", rdata1, 32'hA5A5A5A5);
        chk("wr_rd_rdata0", rdata0, 0);
        req1 = 0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
